// File: rtl/instr_issue_queue_if.sv
// Handshake and data bundle between fetch, the issue queue and the decode stage.
// The master modport is the environment side (fetch/decode/branch unit); slave is the queue.
interface instr_issue_queue_if;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_type;
    logic [4:0]  out_op;
    logic [23:0] out_fields;
    logic        out_illegal;
    logic        branch_resolved;
    logic        flush;
    logic        hold;

    modport master (
        output in_valid, in_instr, out_ready, branch_resolved, flush,
        input  in_ready, out_valid, out_type, out_op, out_fields, out_illegal, hold
    );

    modport slave (
        input  in_valid, in_instr, out_ready, branch_resolved, flush,
        output in_ready, out_valid, out_type, out_op, out_fields, out_illegal, hold
    );
endinterface

// File: rtl/instr_issue_queue.sv
// Instruction issue FIFO: buffers fetched words and presents the head to decode,
// stalling issue after every branch-class pop until the branch resolves.
module instr_issue_queue #(
    parameter int unsigned DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    instr_issue_queue_if.slave   bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {RUN, HOLD} state_e;

    state_e         state_q, state_d;
    logic [31:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic [31:0]    head;
    logic           head_branch;
    logic           push, pop;
    logic           out_valid;

    assign head        = mem_q[rd_ptr_q];
    assign head_branch = (head[31:29] == 3'b000) || (head[31:29] == 3'b110);
    assign out_valid   = (state_q == RUN) && (count_q != '0);

    assign push = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop  = out_valid && bus.out_ready && !bus.flush;

    assign bus.in_ready  = (count_q != CW'(DEPTH));
    assign bus.out_valid = out_valid;
    assign bus.hold      = (state_q == HOLD);

    // Head fields are forced to zero whenever nothing is being offered.
    always_comb begin
        bus.out_type    = '0;
        bus.out_op      = '0;
        bus.out_fields  = '0;
        bus.out_illegal = 1'b0;
        if (out_valid) begin
            bus.out_type    = head[31:29];
            bus.out_op      = head[28:24];
            bus.out_fields  = head[23:0];
            bus.out_illegal = (head[31:29] == 3'b011) || (head[31:29] == 3'b101) ||
                              (head[31:29] == 3'b111);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN:     if (pop && head_branch) state_d = HOLD;
                HOLD:    if (bus.branch_resolved) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) mem_q[wr_ptr_q] <= bus.in_instr;
        end
    end
endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed-vector bench for instr_issue_queue with hand-computed expectations.
module tb_instr_issue_queue;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    instr_issue_queue_if bus ();

    instr_issue_queue #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid        = 1'b0;
        bus.in_instr        = '0;
        bus.out_ready       = 1'b0;
        bus.branch_resolved = 1'b0;
        bus.flush           = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] w);
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        step();
        bus.in_valid = 1'b0;
    endtask

    logic [31:0] words [5];
    logic [31:0] illeg [3];

    initial begin
        n_vec = 0;
        n_bad = 0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",  32'(bus.out_valid), 32'd0);
        chk("rst_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_hold",   32'(bus.hold),      32'd0);
        chk("rst_fields", 32'(bus.out_fields), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single word latency and pop
        push_one(32'h2A00_0005);
        chk("t1_valid",   32'(bus.out_valid),   32'd1);
        chk("t1_type",    32'(bus.out_type),    32'd1);
        chk("t1_op",      32'(bus.out_op),      32'h0A);
        chk("t1_fields",  32'(bus.out_fields),  32'h5);
        chk("t1_illegal", 32'(bus.out_illegal), 32'd0);
        bus.out_ready = 1'b1;
        step();
        chk("t1_popped",  32'(bus.out_valid),   32'd0);
        chk("t1_hold",    32'(bus.hold),        32'd0);
        bus.out_ready = 1'b0;

        // fill, overflow attempt, pop-then-accept, wrap order
        for (int i = 0; i < 5; i++) words[i] = 32'h2000_0010 + 32'(i);
        for (int i = 0; i < 4; i++) push_one(words[i]);
        chk("t2_full",    32'(bus.in_ready),   32'd0);
        bus.in_valid = 1'b1;
        bus.in_instr = words[4];
        step();
        chk("t2_still_full", 32'(bus.in_ready),   32'd0);
        chk("t2_head0",      32'(bus.out_fields), 32'h10);
        bus.out_ready = 1'b1;
        step();
        chk("t2_ready_after_pop", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        chk("t2_full_again", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("t2_order%0d", i), 32'(bus.out_fields), words[i] & 32'h00FF_FFFF);
            step();
        end
        chk("t2_drained", 32'(bus.out_valid), 32'd0);
        step();
        chk("t2_empty_ready_ignored", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;

        // branch type 000 stall and resolve
        push_one(32'h0200_0000);
        push_one(32'h2A00_0001);
        chk("t3_br_head_op", 32'(bus.out_op), 32'h02);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t3_hold%0d", i),  32'(bus.hold),      32'd1);
            chk($sformatf("t3_valid%0d", i), 32'(bus.out_valid), 32'd0);
            chk($sformatf("t3_mask%0d", i),  32'(bus.out_op),    32'd0);
        end
        bus.out_ready       = 1'b0;
        bus.branch_resolved = 1'b1;
        step();
        bus.branch_resolved = 1'b0;
        chk("t3_resumed_hold",  32'(bus.hold),       32'd0);
        chk("t3_resumed_valid", 32'(bus.out_valid),  32'd1);
        chk("t3_resumed_op",    32'(bus.out_op),     32'h0A);
        chk("t3_resumed_field", 32'(bus.out_fields), 32'h1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("t3_nonbranch_pop", 32'(bus.hold), 32'd0);

        // type 110 hold, push during hold, then flush with resolve and push
        push_one(32'hC300_0000);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("t4_hold", 32'(bus.hold), 32'd1);
        push_one(32'h2000_0077);
        chk("t4_hold_push_valid", 32'(bus.out_valid), 32'd0);
        chk("t4_hold_keeps",      32'(bus.hold),      32'd1);
        bus.flush           = 1'b1;
        bus.branch_resolved = 1'b1;
        bus.in_valid        = 1'b1;
        bus.in_instr        = 32'h2000_00AA;
        bus.out_ready       = 1'b1;
        step();
        idle_inputs();
        chk("t4_flush_hold",  32'(bus.hold),      32'd0);
        chk("t4_flush_valid", 32'(bus.out_valid), 32'd0);
        chk("t4_flush_ready", 32'(bus.in_ready),  32'd1);
        step();
        chk("t4_flush_empty", 32'(bus.out_valid), 32'd0);

        // illegal types issue without holding
        illeg[0] = 32'h6000_0000;
        illeg[1] = 32'hA000_0000;
        illeg[2] = 32'hE000_0000;
        for (int i = 0; i < 3; i++) begin
            push_one(illeg[i]);
            chk($sformatf("t5_valid%0d", i),   32'(bus.out_valid),   32'd1);
            chk($sformatf("t5_illegal%0d", i), 32'(bus.out_illegal), 32'd1);
            chk($sformatf("t5_type%0d", i),    32'(bus.out_type),    32'(illeg[i] >> 29));
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            chk($sformatf("t5_nohold%0d", i),  32'(bus.hold),        32'd0);
            chk($sformatf("t5_gone%0d", i),    32'(bus.out_illegal), 32'd0);
        end

        // asynchronous reset mid-cycle with entries queued
        push_one(32'h2100_0001);
        push_one(32'h2200_0002);
        push_one(32'h2300_0003);
        chk("t6_pre_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(bus.out_valid),  32'd0);
        chk("t6_ready", 32'(bus.in_ready),   32'd1);
        chk("t6_op",    32'(bus.out_op),     32'd0);
        chk("t6_field", 32'(bus.out_fields), 32'd0);
        chk("t6_hold",  32'(bus.hold),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t6_discarded", 32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_issue_queue.md
# instr_issue_queue

Instruction issue buffer feeding the control-signal decoder. Accepts 32-bit instruction words from fetch over a valid/ready handshake, buffers them in a small FIFO, and presents the head's class (`type`) and operation (`op`) fields, plus the remaining instruction bits, to the decode stage. Issue stalls after every branch-class instruction (types 000 and 110) until the branch resolves. Type codes the decoder does not handle are flagged as illegal.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥2.
- `CW`, $clog2(DEPTH)+1: occupancy counter width; derived, do not override.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: reset; asynchronous and active-low.
- `in_valid` in 1: fetch presents a word.
- `in_instr` in 32: instruction word; `type`=[31:29], `op`=[28:24], fields=[23:0].
- `in_ready` out 1: buffer can accept a word; equals not full.
- `out_valid` out 1: head available for issue.
- `out_ready` in 1: decode stage consumes the head.
- `out_type` out 3: head [31:29].
- `out_op` out 5: head [28:24].
- `out_fields` out 24: head [23:0].
- `out_illegal` out 1: head type ∈ {011, 101, 111}.
- `branch_resolved` in 1: single-cycle pulse ending a branch hold.
- `flush` in 1: discards all buffered words and any hold.
- `hold` out 1: FSM is in HOLD.

## Operation
- Storage: circular buffer with write pointer, read pointer, and `count` (CW bits). Pointers wrap modulo DEPTH.
- Push: `in_valid && in_ready && !flush`. Pop: `out_valid && out_ready && !flush`.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- `in_ready` = (`count` != DEPTH). It is derived from registered state only and never depends on `out_ready`.
- FSM states:
  - RUN:
    - `out_valid` = (`count` != 0).
    - A pop whose `out_type` is 000 or 110 moves the FSM to HOLD.
    - Any other pop stays in RUN.
  - HOLD:
    - `out_valid` = 0.
    - Pushes are still accepted while space remains.
    - `branch_resolved` = 1 moves the FSM to RUN.
  - `branch_resolved` in RUN is ignored.
- Flush:
  - Clears `count` and both pointers, and forces RUN on the next edge.
  - Overrides any push, pop, or resolve in the same cycle; the pushed word is dropped.
- Illegal types:
  - `out_illegal` is asserted alongside `out_valid` for the head entry.
  - The entry issues and pops normally and never causes a HOLD.
- Output masking: when `out_valid` = 0, `out_type`, `out_op`, `out_fields` and `out_illegal` are driven to 0.
- Reset (asynchronous, `rst_n` = 0):
  - `count`, pointers and stored words are cleared; state = RUN.
  - `out_valid` = 0, `in_ready` = 1, `hold` = 0, and all data outputs = 0.
  - Reset mid-transfer discards all contents.

## Timing
- Latency: a word pushed at edge N is visible at the outputs after edge N, provided the FIFO was empty and the state is RUN. Minimum latency is 1 cycle.
- Head outputs are a combinational read of registered storage, gated by state. There is no combinational path from `in_*` to `out_*`.
- Branch pop at edge N:
  - `hold` = 1 and `out_valid` = 0 from edge N onward.
  - `branch_resolved` sampled at edge M > N returns the FSM to RUN; `out_valid` can reassert after edge M.
  - Minimum bubble is 1 cycle: resolve is asserted in the cycle after the branch pop.
- Full: with `count` = DEPTH, `in_ready` = 0. A pop at edge N makes `in_ready` = 1 after edge N, not in the same cycle.
- Empty in RUN: `out_valid` = 0; `out_ready` is ignored.

## Test plan
- Reset then push 0x2A000005 (type 001, op 0x0A): `out_valid` = 1 one cycle later with `out_type` = 001, `out_op` = 01010, `out_fields` = 0x000005, `out_illegal` = 0. Hold `out_ready` = 1: pop, and `out_valid` returns to 0.
- Push 5 words with `out_ready` = 0: the first 4 are accepted; `in_ready` = 0 after the 4th. Pop one: `in_ready` = 1 next cycle; the 5th word is accepted, and FIFO order is preserved across pointer wrap.
- Queue 0x02000000 (type 000) then 0x2A000001, and pop the branch: `hold` = 1, `out_valid` = 0 for 3 cycles. Pulse `branch_resolved`: the next cycle shows `out_valid` = 1 with `out_op` = 01010.
- Type 110 (0xC3000000) pops into HOLD. Assert `flush` and `branch_resolved` together with `in_valid`: next cycle state = RUN, `count` = 0, the pushed word is dropped, and `out_valid` = 0.
- Push 0x60000000 (type 011): `out_illegal` = 1 with `out_valid` = 1; the pop does not enter HOLD.
- With 3 entries queued, drop `rst_n` asynchronously mid-cycle: `out_valid` = 0 and `in_ready` = 1 immediately, and the outputs read zero.
